pulse_tx_encoder: RTL and testbench

Single-wire pulse-width transmitter: accepts parallel words over a valid/ready handshake and serialises them MSB-first as fixed-period bits whose high time encodes the bit value (short high = 0, long high = 1), followed by an optional low latch period. It is the transmit counterpart of the pulse-width measurement path. It drives LED-chain style lines and provides a loopback stimulus source for the receive side. Timing derives from an internal clock-enable divider that restarts at each word start to remove phase jitter.

---
 rtl/pulse_tx_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_pulse_tx_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_tx_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pulse_tx_encoder                                            |
// | Function : Single-wire pulse-width transmitter. Words are serialised   |
// |            MSB-first as fixed-period bits whose high time encodes the  |
// |            bit value (short high = 0, long high = 1).                  |
// | Options  : PULSE_TX_LATCH_EN - when defined, a LATCH_TICKS low period  |
// |            follows the last queued word before returning to idle.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pulse_tx_encoder #(
  parameter int DIVISOR     = 5,
  parameter int WORD_BITS   = 24,
  parameter int T0H_TICKS   = 4,
  parameter int T1H_TICKS   = 8,
  parameter int BIT_TICKS   = 12,
  parameter int LATCH_TICKS = 500
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [WORD_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_dout,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [DW-1:0] c_div_last  = DW'(DIVISOR - 1);
  localparam logic [TW-1:0] c_t0h_ticks = TW'(T0H_TICKS);
  localparam logic [TW-1:0] c_t1h_ticks = TW'(T1H_TICKS);
  localparam logic [TW-1:0] c_bit_ticks = TW'(BIT_TICKS);
  localparam logic [BW-1:0] c_last_bit  = BW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2
`ifdef PULSE_TX_LATCH_EN
    ,
    S_LATCH = 2'd3
`endif
  } state_t;

  state_t                r_state;
  logic [WORD_BITS-1:0]  r_hold_data;
  logic                  r_hold_full;
  logic [WORD_BITS-1:0]  r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_tick_cnt;
  logic [DW-1:0]         r_div;
  logic                  r_dout;
  logic                  r_done;

  logic                  w_tick;
  logic [TW-1:0]         w_tick_nxt;
  logic [TW-1:0]         w_high_ticks;
  logic                  w_bit_end;
  logic                  w_last_bit;
  logic                  w_load;

`ifdef PULSE_TX_LATCH_EN
  localparam int LW = $clog2(LATCH_TICKS + 1);
  localparam logic [LW-1:0] c_latch_ticks = LW'(LATCH_TICKS);
  logic [LW-1:0]         r_latch_cnt;
  logic [LW-1:0]         w_latch_nxt;
  assign w_latch_nxt = r_latch_cnt + LW'(1);
`else
  // Latch length has no meaning without the latch period; kept only so the
  // parameter list stays identical in both builds.
  logic w_unused_latch;
  assign w_unused_latch = |LATCH_TICKS;
`endif

  assign w_tick       = (r_div == c_div_last);
  assign w_tick_nxt   = r_tick_cnt + TW'(1);
  assign w_high_ticks = r_shift[WORD_BITS-1] ? c_t1h_ticks : c_t0h_ticks;
  assign w_bit_end    = (r_state == S_LOW) && w_tick && (w_tick_nxt == c_bit_ticks);
  assign w_last_bit   = (r_bit_cnt == c_last_bit);
  // A queued word moves into the shift register either from idle or at the
  // exact end of the previous word's last bit, giving gapless streaming.
  assign w_load       = r_hold_full && ((r_state == S_IDLE) || (w_bit_end && w_last_bit));

  assign o_ready = !r_hold_full;
  assign o_busy  = (r_state != S_IDLE) || r_hold_full;
  assign o_dout  = r_dout;
  assign o_done  = r_done;

  // Clock-enable divider; restarted on every word load so each word starts phase-aligned.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div <= '0;
    end else if (w_load || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // One-word holding register: filled by the handshake, emptied by a load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (i_valid && !r_hold_full) begin
      r_hold_data <= i_data;
      r_hold_full <= 1'b1;
    end
  end

  // Transmit state machine with registered line and done outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
      r_dout     <= 1'b0;
      r_done     <= 1'b0;
`ifdef PULSE_TX_LATCH_EN
      r_latch_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dout <= 1'b0;
          if (w_load) begin
            r_shift    <= r_hold_data;
            r_bit_cnt  <= '0;
            r_tick_cnt <= '0;
            r_state    <= S_HIGH;
            r_dout     <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_tick_cnt <= w_tick_nxt;
            if (w_tick_nxt == w_high_ticks) begin
              r_state <= S_LOW;
              r_dout  <= 1'b0;
            end
          end
        end
        S_LOW: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            if (!w_last_bit) begin
              r_shift   <= {r_shift[WORD_BITS-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_state   <= S_HIGH;
              r_dout    <= 1'b1;
            end else if (w_load) begin
              r_shift   <= r_hold_data;
              r_bit_cnt <= '0;
              r_state   <= S_HIGH;
              r_dout    <= 1'b1;
            end else begin
`ifdef PULSE_TX_LATCH_EN
              r_latch_cnt <= '0;
              r_state     <= S_LATCH;
`else
              r_state <= S_IDLE;
              r_done  <= 1'b1;
`endif
            end
          end else if (w_tick) begin
            r_tick_cnt <= w_tick_nxt;
          end
        end
`ifdef PULSE_TX_LATCH_EN
        S_LATCH: begin
          if (w_tick) begin
            if (w_latch_nxt == c_latch_ticks) begin
              r_latch_cnt <= '0;
              r_state     <= S_IDLE;
              // A word that arrived during the latch continues the stream,
              // so the transmission is not yet finished.
              r_done      <= !r_hold_full;
            end else begin
              r_latch_cnt <= w_latch_nxt;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_dout  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_tx_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_pulse_tx_encoder                                         |
// | Function : Self-checking bench for pulse_tx_encoder. Two instances:    |
// |            default timing and a small-parameter sweep. Expected line   |
// |            waveforms come from a word-level timing model.              |
// | Options  : honours PULSE_TX_LATCH_EN like the design.                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_pulse_tx_encoder;

  localparam int WB = 24;
  localparam int DA = 5, T0A = 4, T1A = 8, BTA = 12, LTA = 500;
  localparam int DB = 2, T0B = 1, T1B = 2, BTB = 3, LTB = 7;
`ifdef PULSE_TX_LATCH_EN
  localparam bit LATCH_ON = 1'b1;
`else
  localparam bit LATCH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [WB-1:0] data;
  logic          valid;
  logic          sel;
  logic          valid_a, valid_b;
  logic          ready_a, dout_a, busy_a, done_a;
  logic          ready_b, dout_b, busy_b, done_b;
  logic          ready_s, dout_s, busy_s, done_s;

  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign ready_s = sel ? ready_b : ready_a;
  assign dout_s  = sel ? dout_b  : dout_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;

  pulse_tx_encoder #(
    .DIVISOR(DA), .WORD_BITS(WB), .T0H_TICKS(T0A), .T1H_TICKS(T1A),
    .BIT_TICKS(BTA), .LATCH_TICKS(LTA)
  ) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid_a),
    .o_ready(ready_a), .o_dout(dout_a), .o_busy(busy_a), .o_done(done_a)
  );

  pulse_tx_encoder #(
    .DIVISOR(DB), .WORD_BITS(WB), .T0H_TICKS(T0B), .T1H_TICKS(T1B),
    .BIT_TICKS(BTB), .LATCH_TICKS(LTB)
  ) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid_b),
    .o_ready(ready_b), .o_dout(dout_b), .o_busy(busy_b), .o_done(done_b)
  );

  int vectors = 0;
  int errors  = 0;

  logic [WB-1:0] words[$];
  int            exp_start[$];
  int            exp_done[$];
  int            exp_len;
  logic          obs_dout[$];
  logic          obs_done[$];
  logic          obs_ready[$];
  logic          obs_busy[$];

  // Word-level timing model; index 0 is the first clock the line is high.
  // gap < 0: words queued back to back; gap >= 0: second word offered at that index.
  task automatic build_model(input int gap, input int d, input int bt, input int lt);
    int wbd, ld, end_prev, lend, avail, st;
    wbd = WB * bt * d;
    ld  = LATCH_ON ? lt * d : 0;
    exp_start.delete();
    exp_done.delete();
    for (int k = 0; k < words.size(); k++) begin
      if (k == 0) begin
        exp_start.push_back(0);
      end else begin
        end_prev = exp_start[k-1] + wbd;
        lend     = end_prev + ld;
        avail    = (gap < 0) ? 0 : gap + 2;
        if (avail <= end_prev) st = end_prev;
        else if (avail <= lend) st = lend + 1;
        else begin
          exp_done.push_back(lend);
          st = avail;
        end
        exp_start.push_back(st);
      end
    end
    exp_done.push_back(exp_start[words.size()-1] + wbd + ld);
    exp_len = exp_done[exp_done.size()-1] + 3;
  endtask

  // Drive the word list into the selected instance, record its outputs, compare to the model.
  task automatic run_stream(input string name, input int gap, input int d,
                            input int t0, input int t1, input int bt, input int lt);
    int k, wait_cyc, bd, s, exp_h, obs_h, stray, dl;
    bit acc_next, started, ok;
    bit cov[];
    logic [WB-1:0] w;
    int obs_dl[$];
    build_model(gap, d, bt, lt);
    obs_dout.delete(); obs_done.delete(); obs_ready.delete(); obs_busy.delete();
    k = 0; wait_cyc = 0; acc_next = 0; started = 0;
    data  = words[0];
    valid = 1'b1;
    if (ready_s) acc_next = 1;
    while (obs_dout.size() < exp_len) begin
      @(negedge clk);
      if (!started) begin
        if (dout_s) started = 1;
        else begin
          wait_cyc++;
          if (wait_cyc > 100) begin
            vectors++; errors++;
            $display("FAIL %s start: line never rose, got dout=%0b required 1", name, dout_s);
            valid = 1'b0;
            return;
          end
        end
      end
      if (started) begin
        obs_dout.push_back(dout_s);
        obs_done.push_back(done_s);
        obs_ready.push_back(ready_s);
        obs_busy.push_back(busy_s);
      end
      if (acc_next) begin
        acc_next = 0;
        k++;
        if (k < words.size() && gap < 0) begin
          data  = words[k];
          valid = 1'b1;
        end else begin
          valid = 1'b0;
        end
      end
      if (gap >= 0 && k == 1 && !valid && started && obs_dout.size() - 1 == gap) begin
        data  = words[1];
        valid = 1'b1;
      end
      if (valid && ready_s) acc_next = 1;
    end
    valid = 1'b0;

    bd  = bt * d;
    cov = new[exp_len];
    for (int i = 0; i < exp_len; i++) cov[i] = 0;
    for (int kk = 0; kk < words.size(); kk++) begin
      w = words[kk];
      for (int b = 0; b < WB; b++) begin
        s     = exp_start[kk] + b * bd;
        exp_h = w[WB-1-b] ? t1 * d : t0 * d;
        ok    = 1; obs_h = 0;
        for (int i = 0; i < bd; i++) begin
          cov[s+i] = 1;
          if (obs_dout[s+i] !== ((i < exp_h) ? 1'b1 : 1'b0)) ok = 0;
          if (obs_dout[s+i] === 1'b1) obs_h++;
        end
        vectors++;
        if (!ok) begin
          errors++;
          $display("FAIL %s word%0d bit%0d: %0d high clocks (pattern wrong), required %0d high then %0d low",
                   name, kk, WB-1-b, obs_h, exp_h, bd - exp_h);
        end
      end
    end
    stray = 0;
    for (int i = 0; i < exp_len; i++) if (!cov[i] && obs_dout[i] !== 1'b0) stray++;
    vectors++;
    if (stray != 0) begin
      errors++;
      $display("FAIL %s idle_line: %0d high clocks outside bits, required 0", name, stray);
    end
    for (int i = 0; i < obs_done.size(); i++) if (obs_done[i] === 1'b1) obs_dl.push_back(i);
    vectors++;
    if (obs_dl.size() != exp_done.size()) begin
      errors++;
      $display("FAIL %s done_count: got %0d pulses, required %0d", name, obs_dl.size(), exp_done.size());
    end else begin
      for (int i = 0; i < exp_done.size(); i++) begin
        vectors++;
        if (obs_dl[i] != exp_done[i]) begin
          errors++;
          $display("FAIL %s done_time%0d: at clock %0d, required %0d", name, i, obs_dl[i], exp_done[i]);
        end
      end
    end
    for (int kk = 1; kk < words.size(); kk++) begin
      if (exp_start[kk] == exp_start[kk-1] + WB * bd) begin
        vectors++;
        if (obs_ready[exp_start[kk]-1] !== 1'b0 || obs_ready[exp_start[kk]] !== 1'b1) begin
          errors++;
          $display("FAIL %s ready_rise%0d: ready %0b->%0b at clock %0d, required 0->1", name, kk,
                   obs_ready[exp_start[kk]-1], obs_ready[exp_start[kk]], exp_start[kk]);
        end
      end
    end
    dl = exp_done[exp_done.size()-1];
    vectors++;
    if (obs_busy[dl-1] !== 1'b1 || obs_busy[dl] !== 1'b0 || obs_ready[dl] !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_end: busy %0b->%0b ready %0b, required busy 1->0 ready 1",
               name, obs_busy[dl-1], obs_busy[dl], obs_ready[dl]);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({dout_a, ready_a, busy_a, done_a} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_a: dout/ready/busy/done=%b, required 0100", {dout_a, ready_a, busy_a, done_a});
    end
    vectors++;
    if ({dout_b, ready_b, busy_b, done_b} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_b: dout/ready/busy/done=%b, required 0100", {dout_b, ready_b, busy_b, done_b});
    end
  endtask

  task automatic test_single();
    sel = 1'b0;
    words = '{24'h800001};
    run_stream("single_800001", -1, DA, T0A, T1A, BTA, LTA);
    words = '{24'h000000};
    run_stream("single_000000", -1, DA, T0A, T1A, BTA, LTA);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    words = '{24'($urandom), 24'hFFFFFF};
    run_stream("back_to_back", -1, DA, T0A, T1A, BTA, LTA);
  endtask

  task automatic test_random();
    int n;
    sel = 1'b0;
    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(1, 3);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(24'($urandom));
      run_stream("random_stream", -1, DA, T0A, T1A, BTA, LTA);
    end
  endtask

  task automatic test_late_word();
    int wbd, ld;
    sel = 1'b0;
    wbd = WB * BTA * DA;
    ld  = LATCH_ON ? LTA * DA : 0;
    words = '{24'($urandom), 24'($urandom)};
    run_stream("word_in_latch", wbd + ld / 2 + 10, DA, T0A, T1A, BTA, LTA);
    words = '{24'($urandom), 24'($urandom)};
    run_stream("word_late_rand", wbd - 3 + $urandom_range(0, ld + 10), DA, T0A, T1A, BTA, LTA);
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    sel   = 1'b0;
    data  = 24'($urandom);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!dout_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dout_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_start: dout=%0b, required 1", dout_a);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dout_a, ready_a, busy_a, done_a} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid_async: dout/ready/busy/done=%b, required 0100", {dout_a, ready_a, busy_a, done_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a !== 1'b0 || dout_a !== 1'b0) seen = 1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after reset=%0b, required 0", seen);
    end
    words = '{24'($urandom)};
    run_stream("after_reset", -1, DA, T0A, T1A, BTA, LTA);
  endtask

  task automatic test_sweep();
    sel = 1'b1;
    words = '{24'hA5F00F, 24'($urandom), 24'($urandom)};
    run_stream("sweep_b2b", -1, DB, T0B, T1B, BTB, LTB);
    words = '{24'($urandom), 24'($urandom)};
    run_stream("sweep_late", WB * BTB * DB + 2, DB, T0B, T1B, BTB, LTB);
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_back_to_back();
    test_random();
    test_late_word();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
